mem_arbiter: RTL and testbench

//   Two-port round-robin arbiter sharing one single-port word memory (the MEM block)

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: owner ids, FSM states,
// default widths.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a pointer register that favours
// the side not granted last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    owner_t ptr;

    assign gnt_a = req_a & (~req_b | (ptr == OWN_A));
    assign gnt_b = req_b & (~req_a | (ptr == OWN_B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= OWN_A;
        end else if (gnt_a) begin
            ptr <= OWN_B;
        end else if (gnt_b) begin
            ptr <= OWN_A;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single-port word memory, 2-cycle response.
// Optional MEM_ARB_ALIGN_CHECK_EN: misaligned requests answer with rsp_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
`ifdef MEM_ARB_ALIGN_CHECK_EN
    output logic                  a_rsp_err,
    output logic                  b_rsp_err,
`endif
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic                  gnt_a;
    logic                  gnt_b;
    logic                  accept;
    owner_t                sel_own;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_bad;
    state_t                state_q;
    state_t                state_d;
    owner_t                s2_own;
    logic                  s2_we;
    logic                  s2_err;
    logic [DATA_WIDTH-1:0] rsp_data;

    // Reset also blocks acceptance so no ready is seen while held in reset.
    rr_arb2 u_rr (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .req_a (a_req_valid & sys_rst_n),
        .req_b (b_req_valid & sys_rst_n),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;
    assign accept      = gnt_a | gnt_b;
    assign sel_own     = gnt_b ? OWN_B : OWN_A;
    assign sel_we      = gnt_b ? b_req_we : a_req_we;
    assign sel_addr    = gnt_b ? b_req_addr : a_req_addr;
    assign sel_wdata   = gnt_b ? b_req_wdata : a_req_wdata;

`ifdef MEM_ARB_ALIGN_CHECK_EN
    assign sel_bad = |sel_addr[1:0];
`else
    assign sel_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (accept)  state_d = ACTIVE;
            ACTIVE: if (!accept) state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // S1 -> S2: misaligned commands keep the MEM pins untouched.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            s2_own    <= OWN_A;
            s2_we     <= 1'b0;
            s2_err    <= 1'b0;
        end else begin
            mem_we <= accept & sel_we & ~sel_bad;
            if (accept) begin
                s2_own <= sel_own;
                s2_we  <= sel_we;
                s2_err <= sel_bad;
            end
            if (accept && !sel_bad) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    assign rsp_data = (s2_we || s2_err) ? '0 : mem_rdata;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            a_rsp_rdata <= '0;
            b_rsp_rdata <= '0;
        end else begin
            a_rsp_valid <= (state_q == ACTIVE) && (s2_own == OWN_A);
            b_rsp_valid <= (state_q == ACTIVE) && (s2_own == OWN_B);
            if (state_q == ACTIVE && s2_own == OWN_A) a_rsp_rdata <= rsp_data;
            if (state_q == ACTIVE && s2_own == OWN_B) b_rsp_rdata <= rsp_data;
        end
    end

`ifdef MEM_ARB_ALIGN_CHECK_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_rsp_err <= 1'b0;
            b_rsp_err <= 1'b0;
        end else begin
            if (state_q == ACTIVE && s2_own == OWN_A) a_rsp_err <= s2_err;
            if (state_q == ACTIVE && s2_own == OWN_B) b_rsp_err <= s2_err;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory behind it.
// Build with MEM_ARB_ALIGN_CHECK_EN to also cover the alignment check.
module tb_mem_arbiter;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid;
    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    logic        a_rsp_err, b_rsp_err;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] mem [0:63];

    mem_arbiter dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
`ifdef MEM_ARB_ALIGN_CHECK_EN
        .a_rsp_err   (a_rsp_err),
        .b_rsp_err   (b_rsp_err),
`endif
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge sys_clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0;
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        idle_inputs();
        repeat (3) tick();
        sys_rst_n = 1;
    endtask

    task automatic req_a(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    endtask

    task automatic req_b(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        b_req_valid = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        sys_rst_n = 0;
        idle_inputs();
        repeat (2) tick();
        #1;
        // reset state
        check("rst_a_ready", a_req_ready, 0);
        check("rst_b_ready", b_req_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_a_rsp", a_rsp_valid, 0);
        check("rst_b_rsp", b_rsp_valid, 0);
        check("rst_a_rdata", a_rsp_rdata, 0);
        check("rst_b_rdata", b_rsp_rdata, 0);
        tick();
        sys_rst_n = 1;

        // A write 0x11 -> 0x30, then read back
        req_a(1, 32'h30, 32'h11);
        #1;
        check("t2_a_ready", a_req_ready, 1);
        check("t2_b_ready", b_req_ready, 0);
        tick();
        idle_inputs();
        check("t2_mem_we", mem_we, 1);
        check("t2_mem_addr", mem_addr, 32'h30);
        check("t2_mem_wdata", mem_wdata, 32'h11);
        check("t2_rsp_early", a_rsp_valid, 0);
        tick();
        check("t2_wr_rsp", a_rsp_valid, 1);
        check("t2_wr_rdata", a_rsp_rdata, 0);
        check("t2_idle_we", mem_we, 0);
        req_a(0, 32'h30, 32'h0);
        #1;
        check("t2_rd_ready", a_req_ready, 1);
        tick();
        idle_inputs();
        check("t2_rd_we", mem_we, 0);
        check("t2_rd_addr", mem_addr, 32'h30);
        check("t2_rsp_pulse", a_rsp_valid, 0);
        tick();
        check("t2_rd_rsp", a_rsp_valid, 1);
        check("t2_rd_rdata", a_rsp_rdata, 32'h11);
        tick();
        check("t2_rsp_off", a_rsp_valid, 0);
        check("t2_rdata_hold", a_rsp_rdata, 32'h11);

        // both requesters contend for 6 cycles
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                req_a(0, 32'h30, 32'h0);
                req_b(1, 32'h40 + 4 * i, 32'hB0 + i);
            end else begin
                idle_inputs();
            end
            #1;
            check($sformatf("t3_a_ready%0d", i), a_req_ready,
                  (i < 6) && (i % 2 == 0));
            check($sformatf("t3_b_ready%0d", i), b_req_ready,
                  (i < 6) && (i % 2 == 1));
            check($sformatf("t3_we%0d", i), mem_we,
                  (i >= 1) && (i <= 6) && (i % 2 == 0));
            if (i >= 2) begin
                check($sformatf("t3_a_rsp%0d", i), a_rsp_valid, i % 2 == 0);
                check($sformatf("t3_b_rsp%0d", i), b_rsp_valid, i % 2 == 1);
                if (i % 2 == 0)
                    check($sformatf("t3_a_rd%0d", i), a_rsp_rdata, 32'h11);
            end
            tick();
        end
        check("t3_b_wr_mem", mem[(32'h44) >> 2], 32'hB1);

        // write then read of same address from the other side
        req_a(1, 32'h34, 32'hDEAD);
        #1;
        check("t4_a_ready", a_req_ready, 1);
        tick();
        idle_inputs();
        req_b(0, 32'h34, 32'h0);
        #1;
        check("t4_b_ready", b_req_ready, 1);
        tick();
        idle_inputs();
        check("t4_a_rsp", a_rsp_valid, 1);
        tick();
        check("t4_b_rsp", b_rsp_valid, 1);
        check("t4_b_rdata", b_rsp_rdata, 32'hDEAD);
        tick();

        // reset while a write sits in S2
        req_b(1, 32'h38, 32'h55);
        #1;
        check("t5_b_ready", b_req_ready, 1);
        tick();
        idle_inputs();
        check("t5_we_staged", mem_we, 1);
        sys_rst_n = 0;
        #1;
        check("t5_we_drop", mem_we, 0);
        tick();
        check("t5_no_rsp", b_rsp_valid, 0);
        sys_rst_n = 1;
        req_a(0, 32'h38, 32'h0);
        req_b(0, 32'h30, 32'h0);
        #1;
        check("t5_ptr_a", a_req_ready, 1);
        check("t5_ptr_b", b_req_ready, 0);
        tick();
        idle_inputs();
        tick();
        check("t5_rd_rsp", a_rsp_valid, 1);
        check("t5_not_written", a_rsp_rdata, 0);
        tick();

`ifdef MEM_ARB_ALIGN_CHECK_EN
        // misaligned write is answered with an error and never hits memory
        req_b(1, 32'h31, 32'h77);
        #1;
        check("t6_b_ready", b_req_ready, 1);
        tick();
        idle_inputs();
        req_b(0, 32'h30, 32'h0);
        #1;
        check("t6_we_blocked", mem_we, 0);
        tick();
        idle_inputs();
        check("t6_err_rsp", b_rsp_valid, 1);
        check("t6_err_flag", b_rsp_err, 1);
        check("t6_err_rdata", b_rsp_rdata, 0);
        tick();
        check("t6_ok_rsp", b_rsp_valid, 1);
        check("t6_ok_err", b_rsp_err, 0);
        check("t6_ok_rdata", b_rsp_rdata, 32'h11);
        check("t6_a_err", a_rsp_err, 0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
